// File: rtl/node_injector.sv
// Node-side packet injector: segments descriptors and payload words into flits on one VC per packet.
// Optional build macro NODE_INJ_RR_VC_EN selects round-robin VC choice; otherwise fixed priority.

package noc_params;
    localparam int VC_NUM            = 2;
    localparam int VC_SIZE           = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
    localparam int DEST_ADDR_SIZE_X  = 2;
    localparam int DEST_ADDR_SIZE_Y  = 2;
    localparam int FLIT_DATA_SIZE    = 16;
    localparam int HEAD_PAYLOAD_SIZE = FLIT_DATA_SIZE - DEST_ADDR_SIZE_X - DEST_ADDR_SIZE_Y;

    typedef enum logic [1:0] {
        HEAD     = 2'd0,
        BODY     = 2'd1,
        TAIL     = 2'd2,
        HEADTAIL = 2'd3
    } flit_label_t;

    typedef struct packed {
        logic [DEST_ADDR_SIZE_X-1:0]  x_dest;
        logic [DEST_ADDR_SIZE_Y-1:0]  y_dest;
        logic [HEAD_PAYLOAD_SIZE-1:0] head_pl;
    } head_data_t;

    typedef union packed {
        head_data_t                head_data;
        logic [FLIT_DATA_SIZE-1:0] bt_pl;
    } flit_data_t;

    typedef struct packed {
        flit_label_t        flit_label;
        logic [VC_SIZE-1:0] vc_id;
        flit_data_t         data;
    } flit_t;
endpackage

// state | meaning
// IDLE  | ready for a new descriptor
// ALLOC | waiting for a VC that is both allocatable and on; issues the head flit
// SEND  | streaming body/tail flits on the latched VC while its credit is on
module node_injector
    import noc_params::*;
#(
    parameter int MAX_PKT_LEN = 8
)(
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             pkt_valid_i,
    output logic                             pkt_ready_o,
    input  logic [DEST_ADDR_SIZE_X-1:0]      pkt_x_dest_i,
    input  logic [DEST_ADDR_SIZE_Y-1:0]      pkt_y_dest_i,
    input  logic [$clog2(MAX_PKT_LEN+1)-1:0] pkt_len_i,
    input  logic [HEAD_PAYLOAD_SIZE-1:0]     pkt_head_pl_i,
    input  logic                             pl_valid_i,
    output logic                             pl_ready_o,
    input  logic [FLIT_DATA_SIZE-1:0]        pl_data_i,
    output flit_t                            data_o,
    output logic                             is_valid_o,
    input  logic [VC_NUM-1:0]                is_on_off_i,
    input  logic [VC_NUM-1:0]                is_allocatable_i
);

    localparam int LEN_W = $clog2(MAX_PKT_LEN + 1);
    localparam int CNT_W = (MAX_PKT_LEN > 1) ? $clog2(MAX_PKT_LEN) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALLOC = 2'd1,
        SEND  = 2'd2
    } state_t;

    state_t                       state_q, state_d;
    logic [LEN_W-1:0]             len_q, len_norm;
    logic [CNT_W-1:0]             cnt_q;
    logic [DEST_ADDR_SIZE_X-1:0]  x_q;
    logic [DEST_ADDR_SIZE_Y-1:0]  y_q;
    logic [HEAD_PAYLOAD_SIZE-1:0] head_pl_q;
    logic [VC_SIZE-1:0]           vc_q;
    flit_t                        data_q, flit_d;
    logic                         valid_q, valid_d;

    logic [VC_NUM-1:0]            cand;
    logic [VC_SIZE-1:0]           sel_vc;
    logic                         sel_found;
    logic                         accept, head_fire, bt_fire;
    logic                         single_flit, last_flit;

    assign cand        = is_allocatable_i & is_on_off_i;
    assign single_flit = (len_q == LEN_W'(1));
    assign last_flit   = (LEN_W'(cnt_q) == (len_q - LEN_W'(1)));
    assign data_o      = data_q;
    assign is_valid_o  = valid_q;

    // Zero-length requests still carry a head, so they become single-flit packets.
    always_comb begin
        len_norm = pkt_len_i;
        if (pkt_len_i == '0) begin
            len_norm = LEN_W'(1);
        end else if (pkt_len_i > LEN_W'(MAX_PKT_LEN)) begin
            len_norm = LEN_W'(MAX_PKT_LEN);
        end
    end

`ifdef NODE_INJ_RR_VC_EN
    logic [VC_SIZE-1:0] last_vc_q;

    always_comb begin
        sel_found = 1'b0;
        sel_vc    = '0;
        for (int i = 0; i < VC_NUM; i++) begin
            if (!sel_found && cand[(int'(last_vc_q) + 1 + i) % VC_NUM]) begin
                sel_found = 1'b1;
                sel_vc    = VC_SIZE'((int'(last_vc_q) + 1 + i) % VC_NUM);
            end
        end
    end

    // Reset value makes the very first search start at VC0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_vc_q <= VC_SIZE'(VC_NUM - 1);
        end else if (head_fire) begin
            last_vc_q <= sel_vc;
        end
    end
`else
    always_comb begin
        sel_found = 1'b0;
        sel_vc    = '0;
        for (int i = 0; i < VC_NUM; i++) begin
            if (!sel_found && cand[i]) begin
                sel_found = 1'b1;
                sel_vc    = VC_SIZE'(i);
            end
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        flit_d      = '0;
        valid_d     = 1'b0;
        pkt_ready_o = 1'b0;
        pl_ready_o  = 1'b0;
        accept      = 1'b0;
        head_fire   = 1'b0;
        bt_fire     = 1'b0;

        case (state_q)
            IDLE: begin
                pkt_ready_o = rst;
                if (pkt_valid_i && rst) begin
                    accept  = 1'b1;
                    state_d = ALLOC;
                end
            end

            ALLOC: begin
                if (sel_found) begin
                    head_fire                     = 1'b1;
                    valid_d                       = 1'b1;
                    flit_d.flit_label             = single_flit ? HEADTAIL : HEAD;
                    flit_d.vc_id                  = sel_vc;
                    flit_d.data.head_data.x_dest  = x_q;
                    flit_d.data.head_data.y_dest  = y_q;
                    flit_d.data.head_data.head_pl = head_pl_q;
                    state_d                       = single_flit ? IDLE : SEND;
                end
            end

            SEND: begin
                // Only the latched VC's credit matters; allocatable flags are ignored here.
                pl_ready_o = is_on_off_i[vc_q];
                if (pl_valid_i && pl_ready_o) begin
                    bt_fire           = 1'b1;
                    valid_d           = 1'b1;
                    flit_d.flit_label = last_flit ? TAIL : BODY;
                    flit_d.vc_id      = vc_q;
                    flit_d.data.bt_pl = pl_data_i;
                    if (last_flit) begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            len_q     <= '0;
            cnt_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            head_pl_q <= '0;
            vc_q      <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= flit_d;
            valid_q <= valid_d;
            if (accept) begin
                len_q     <= len_norm;
                x_q       <= pkt_x_dest_i;
                y_q       <= pkt_y_dest_i;
                head_pl_q <= pkt_head_pl_i;
            end
            if (head_fire) begin
                vc_q  <= sel_vc;
                cnt_q <= CNT_W'(1);
            end else if (bt_fire) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_node_injector.sv
// Scoreboard bench for node_injector: expected flits are queued as stimulus is driven
// and popped when the DUT shows a valid flit.

module tb_node_injector;
    import noc_params::*;

    localparam int MAX_PKT_LEN = 8;
    localparam int LEN_W       = $clog2(MAX_PKT_LEN + 1);

    logic                         clk = 1'b0;
    logic                         rst;
    logic                         pkt_valid_i;
    logic                         pkt_ready_o;
    logic [DEST_ADDR_SIZE_X-1:0]  pkt_x_dest_i;
    logic [DEST_ADDR_SIZE_Y-1:0]  pkt_y_dest_i;
    logic [LEN_W-1:0]             pkt_len_i;
    logic [HEAD_PAYLOAD_SIZE-1:0] pkt_head_pl_i;
    logic                         pl_valid_i;
    logic                         pl_ready_o;
    logic [FLIT_DATA_SIZE-1:0]    pl_data_i;
    flit_t                        data_o;
    logic                         is_valid_o;
    logic [VC_NUM-1:0]            is_on_off_i;
    logic [VC_NUM-1:0]            is_allocatable_i;

    node_injector #(.MAX_PKT_LEN(MAX_PKT_LEN)) dut (
        .clk              (clk),
        .rst              (rst),
        .pkt_valid_i      (pkt_valid_i),
        .pkt_ready_o      (pkt_ready_o),
        .pkt_x_dest_i     (pkt_x_dest_i),
        .pkt_y_dest_i     (pkt_y_dest_i),
        .pkt_len_i        (pkt_len_i),
        .pkt_head_pl_i    (pkt_head_pl_i),
        .pl_valid_i       (pl_valid_i),
        .pl_ready_o       (pl_ready_o),
        .pl_data_i        (pl_data_i),
        .data_o           (data_o),
        .is_valid_o       (is_valid_o),
        .is_on_off_i      (is_on_off_i),
        .is_allocatable_i (is_allocatable_i)
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_errors = 0;
    int    tb_last_vc = VC_NUM - 1;
    flit_t exp_q[$];
    flit_t mon_exp;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pick_vc(input logic [VC_NUM-1:0] cand);
`ifdef NODE_INJ_RR_VC_EN
        for (int i = 0; i < VC_NUM; i++) begin
            if (cand[(tb_last_vc + 1 + i) % VC_NUM]) return (tb_last_vc + 1 + i) % VC_NUM;
        end
`else
        for (int i = 0; i < VC_NUM; i++) begin
            if (cand[i]) return i;
        end
`endif
        return 0;
    endfunction

    function automatic flit_t mk_head(input int vc, input flit_label_t lab,
                                      input logic [DEST_ADDR_SIZE_X-1:0] x,
                                      input logic [DEST_ADDR_SIZE_Y-1:0] y,
                                      input logic [HEAD_PAYLOAD_SIZE-1:0] hpl);
        flit_t f;
        f = '0;
        f.flit_label             = lab;
        f.vc_id                  = VC_SIZE'(vc);
        f.data.head_data.x_dest  = x;
        f.data.head_data.y_dest  = y;
        f.data.head_data.head_pl = hpl;
        return f;
    endfunction

    function automatic flit_t mk_bt(input int vc, input flit_label_t lab,
                                    input logic [FLIT_DATA_SIZE-1:0] d);
        flit_t f;
        f = '0;
        f.flit_label = lab;
        f.vc_id      = VC_SIZE'(vc);
        f.data.bt_pl = d;
        return f;
    endfunction

    // Every valid flit must match the oldest expected one.
    always @(negedge clk) begin
        if (rst && is_valid_o) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_flit", 32'(is_valid_o), 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check_eq("flit", 32'(data_o), 32'(mon_exp));
            end
        end
    end

    task automatic send_desc(input logic [DEST_ADDR_SIZE_X-1:0] x,
                             input logic [DEST_ADDR_SIZE_Y-1:0] y,
                             input int len, input logic [HEAD_PAYLOAD_SIZE-1:0] hpl,
                             input bit push_head, output int vc);
        bit got = 0;
        int el;
        pkt_valid_i   = 1'b1;
        pkt_x_dest_i  = x;
        pkt_y_dest_i  = y;
        pkt_len_i     = LEN_W'(len);
        pkt_head_pl_i = hpl;
        vc            = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (pkt_ready_o) begin
                got = 1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!got) check_eq("desc_timeout", 32'(pkt_ready_o), 32'd1);
        el = (len == 0) ? 1 : (len > MAX_PKT_LEN) ? MAX_PKT_LEN : len;
        if (push_head) begin
            vc = pick_vc(is_allocatable_i & is_on_off_i);
            tb_last_vc = vc;
            exp_q.push_back(mk_head(vc, (el == 1) ? HEADTAIL : HEAD, x, y, hpl));
        end
        @(posedge clk); #1;
        pkt_valid_i = 1'b0;
    endtask

    task automatic drive_pl(input int vc, input logic [FLIT_DATA_SIZE-1:0] d, input bit last);
        bit got = 0;
        pl_valid_i = 1'b1;
        pl_data_i  = d;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (pl_ready_o) begin
                exp_q.push_back(mk_bt(vc, last ? TAIL : BODY, d));
                got = 1;
            end
            @(posedge clk); #1;
            if (got) break;
        end
        if (!got) check_eq("pl_timeout", 32'(pl_ready_o), 32'd1);
        pl_valid_i = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int vc;
        rst              = 1'b0;
        pkt_valid_i      = 1'b1;
        pkt_x_dest_i     = '0;
        pkt_y_dest_i     = '0;
        pkt_len_i        = '0;
        pkt_head_pl_i    = '0;
        pl_valid_i       = 1'b0;
        pl_data_i        = '0;
        is_on_off_i      = '1;
        is_allocatable_i = '1;

        // T1: held in reset with a pending descriptor
        repeat (3) begin
            @(negedge clk);
            check_eq("t1_valid", 32'(is_valid_o), 32'd0);
            check_eq("t1_pkt_rdy", 32'(pkt_ready_o), 32'd0);
            check_eq("t1_pl_rdy", 32'(pl_ready_o), 32'd0);
        end
        check_eq("t1_data", 32'(data_o), 32'd0);
        @(posedge clk); #1;
        pkt_valid_i = 1'b0;
        rst         = 1'b1;
        @(negedge clk);
        check_eq("t1_rdy_release", 32'(pkt_ready_o), 32'd1);
        @(posedge clk); #1;

        // T2: single-flit packet, exact timing
        send_desc(2'd2, 2'd1, 1, 12'h5A5, 1'b1, vc);
        @(negedge clk);
        check_eq("t2_alloc_idle", 32'(is_valid_o), 32'd0);
        @(negedge clk);
        check_eq("t2_head_valid", 32'(is_valid_o), 32'd1);
        check_eq("t2_rdy_again", 32'(pkt_ready_o), 32'd1);
        @(negedge clk);
        check_eq("t2_one_pulse", 32'(is_valid_o), 32'd0);
        @(posedge clk); #1;

        // T3: 4-flit packet with a 2-cycle credit drop after the first body
        send_desc(2'd1, 2'd3, 4, 12'h123, 1'b1, vc);
        drive_pl(vc, 16'h000A, 1'b0);
        is_on_off_i[vc] = 1'b0;
        pl_valid_i      = 1'b1;
        pl_data_i       = 16'h000B;
        @(negedge clk);
        check_eq("t3_plr_off0", 32'(pl_ready_o), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("t3_plr_off1", 32'(pl_ready_o), 32'd0);
        check_eq("t3_gap0", 32'(is_valid_o), 32'd0);
        @(posedge clk); #1;
        is_on_off_i[vc] = 1'b1;
        @(negedge clk);
        check_eq("t3_gap1", 32'(is_valid_o), 32'd0);
        check_eq("t3_plr_on", 32'(pl_ready_o), 32'd1);
        exp_q.push_back(mk_bt(vc, BODY, 16'h000B));
        @(posedge clk); #1;
        drive_pl(vc, 16'h000C, 1'b1);
        wait_cycles(2);

        // T4: no candidate VC for 5 cycles
        is_allocatable_i = 2'b01;
        is_on_off_i      = 2'b10;
        send_desc(2'd3, 2'd0, 1, 12'hABC, 1'b0, vc);
        repeat (5) begin
            @(negedge clk);
            check_eq("t4_no_flit", 32'(is_valid_o), 32'd0);
            check_eq("t4_busy", 32'(pkt_ready_o), 32'd0);
            @(posedge clk); #1;
        end
        is_on_off_i = 2'b11;
        vc = pick_vc(is_allocatable_i & is_on_off_i);
        tb_last_vc = vc;
        exp_q.push_back(mk_head(vc, HEADTAIL, 2'd3, 2'd0, 12'hABC));
        wait_cycles(3);
        is_allocatable_i = 2'b11;

        // T5: VC sequence over three single-flit packets from a fresh reset
        rst = 1'b0;
        tb_last_vc = VC_NUM - 1;
        wait_cycles(2);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            send_desc(2'(k), 2'(k + 1), 1, 12'(16 + k), 1'b1, vc);
        end
        // zero length becomes a single HEADTAIL
        send_desc(2'd0, 2'd0, 0, 12'hF0F, 1'b1, vc);
        wait_cycles(3);

        // T6: reset mid-packet
        send_desc(2'd0, 2'd2, 5, 12'h777, 1'b1, vc);
        drive_pl(vc, 16'h0011, 1'b0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        tb_last_vc = VC_NUM - 1;
        #1;
        check_eq("t6_async_valid", 32'(is_valid_o), 32'd0);
        check_eq("t6_async_data", 32'(data_o), 32'd0);
        check_eq("t6_pl_rdy", 32'(pl_ready_o), 32'd0);
        wait_cycles(2);
        rst = 1'b1;
        wait_cycles(2);
        check_eq("t6_no_tail", 32'(is_valid_o), 32'd0);
        send_desc(2'd1, 2'd1, 2, 12'h042, 1'b1, vc);
        drive_pl(vc, 16'h0022, 1'b1);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        wait_cycles(2);
        check_eq("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
